// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the instruction
//   fetch port and the load/store port of the multicycle core. At most one
//   memory transaction is outstanding; its response is routed back to the
//   port that issued it, and the core-wide stall is derived here.
//
// Ports
//   clk, reset                 clock (rising edge) / async active-low reset
//   if_req, if_addr            fetch request and address (held until if_valid)
//   if_rdata, if_valid         fetched word and one-cycle completion pulse
//   d_req, d_we, d_addr,       load/store request, direction, address,
//   d_wdata, d_be              store data and byte enables (held until d_valid)
//   d_rdata, d_valid           load data and one-cycle completion pulse
//   mem_req, mem_we, mem_addr, memory request and registered payload,
//   mem_wdata, mem_be          held stable until mem_gnt
//   mem_gnt, mem_rvalid,       memory accept, response strobe (also write ack)
//   mem_rdata                  and read data
//   stall                      core must hold state while a request is open
//   err                        sticky watchdog timeout flag
//
// Build option
//   MEM_ARB_TIMEOUT_EN: when defined, a watchdog abandons a transaction after
//   TIMEOUT_CYCLES cycles in ISSUE/WAIT, completes it with rdata=0 and sets
//   err. When undefined there is no counter and err is tied low.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                err
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  state_t            state_q, state_d;
  // Owner of the current (or most recent) transaction; it doubles as the
  // last-owner record that drives alternation under contention.
  owner_t            owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic              complete;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_FETCH;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_valid_d   = 1'b0;
    complete    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // While a valid pulse is out the requester still holds its old
        // request, so acceptance waits one cycle to avoid re-issuing it.
        // Stray mem_gnt/mem_rvalid are ignored here by construction.
        if (!if_valid_q && !d_valid_q && (if_req || d_req)) begin
          if (d_req && (!if_req || owner_q == OWN_FETCH)) begin
            owner_d     = OWN_DATA;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_we ? d_be : '1;
          end else begin
            owner_d     = OWN_FETCH;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_rvalid) begin
            complete = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          complete = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (complete) begin
      state_d = S_IDLE;
      if (owner_q == OWN_DATA) begin
        d_rdata_d = mem_rdata;
        d_valid_d = 1'b1;
      end else begin
        if_rdata_d = mem_rdata;
        if_valid_d = 1'b1;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    else if (state_q != S_IDLE) begin
      // Watchdog expiry overrides a grant without response in the same cycle.
      if (cnt_q == CNT_LAST) begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        err_d     = 1'b1;
        if (owner_q == OWN_DATA) begin
          d_rdata_d = '0;
          d_valid_d = 1'b1;
        end else begin
          if_rdata_d = '0;
          if_valid_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

`ifdef MEM_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #2;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h be=%h, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    n_checks++;
    if ({if_valid, if_rdata, d_valid, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: got ifv=%b ifr=%h dv=%b dr=%h, want all 0",
               if_valid, if_rdata, d_valid, d_rdata);
    end
    n_checks++;
    if ({err, stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_err_stall: got err=%b stall=%b, want 0 0", err, stall);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Fetch with gnt in cycle 1 and rvalid in cycle 3; if_valid in cycle 4.
  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %b want 1", stall); end
    tick();
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      n_fail++;
      $display("FAIL fetch_issue: got req=%b we=%b addr=%h be=%h want 1 0 00000100 f",
               mem_req, mem_we, mem_addr, mem_be);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n_checks++;
    if ({mem_req, if_valid} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_c2: got req=%b ifv=%b want 0 0", mem_req, if_valid);
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    n_checks++;
    if ({if_valid, if_rdata, d_valid} !== {1'b1, 32'h0050_0093, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_done: got ifv=%b ifr=%h dv=%b want 1 00500093 0", if_valid, if_rdata, d_valid);
    end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c4: got %b want 0", stall); end
    if_req = 1'b0;
    tick();
    n_checks++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_len: got %b want 0", if_valid); end
  endtask

  // Both ports held across four completions: strict alternation from DATA.
  task automatic test_contention();
    logic exp_data;
    int w;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'h0;
    for (int k = 0; k < 4; k++) begin
      exp_data = (k % 2 == 0);
      w = 0;
      while (mem_req !== 1'b1 && w < 10) begin tick(); w++; end
      n_checks++;
      if (mem_req !== 1'b1) begin n_fail++; $display("FAIL contend_req_%0d: got %b want 1 (timeout)", k, mem_req); end
      if (k > 0) begin
        n_checks++;
        if (w != 2) begin n_fail++; $display("FAIL back_to_back_%0d: got gap %0d want 2", k, w); end
      end
      n_checks++;
      if (mem_addr !== (exp_data ? 32'h2000 : 32'h100)) begin
        n_fail++; $display("FAIL contend_owner_%0d: got addr %h want %h", k, mem_addr, exp_data ? 32'h2000 : 32'h100);
      end
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + k;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      n_checks++;
      if ({d_valid, if_valid} !== {exp_data, ~exp_data}) begin
        n_fail++; $display("FAIL contend_valid_%0d: got dv=%b ifv=%b want %b %b", k, d_valid, if_valid, exp_data, ~exp_data);
      end
      n_checks++;
      if ((exp_data ? d_rdata : if_rdata) !== 32'hA000_0000 + k) begin
        n_fail++; $display("FAIL contend_rdata_%0d: got %h want %h", k, exp_data ? d_rdata : if_rdata, 32'hA000_0000 + k);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
    tick();
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D, 4'b0011}) begin
      n_fail++;
      $display("FAIL store_payload: got req=%b we=%b addr=%h wdata=%h be=%b", mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL store_req_drop: got %b want 0", mem_req); end
    mem_rvalid = 1'b1; mem_rdata = '0;
    tick();
    mem_rvalid = 1'b0;
    n_checks++;
    if ({d_valid, if_valid} !== 2'b10) begin
      n_fail++; $display("FAIL store_valid: got dv=%b ifv=%b want 1 0", d_valid, if_valid);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    n_checks++;
    if ({d_valid, if_valid} !== 2'b00) begin
      n_fail++; $display("FAIL store_pulse_len: got dv=%b ifv=%b want 0 0", d_valid, if_valid);
    end
  endtask

  // Load with gnt and rvalid together in cycle 1; d_valid in cycle 2.
  task automatic test_same_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'b0101;
    tick();
    n_checks++;
    if ({mem_req, mem_we, mem_be} !== {1'b1, 1'b0, 4'hF}) begin
      n_fail++; $display("FAIL same_issue: got req=%b we=%b be=%h want 1 0 f", mem_req, mem_we, mem_be);
    end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    n_checks++;
    if ({d_valid, d_rdata, mem_req} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      n_fail++; $display("FAIL same_done: got dv=%b dr=%h req=%b want 1 12345678 0", d_valid, d_rdata, mem_req);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_addr, d_valid, d_rdata, if_rdata, err} !== '0) begin
      n_fail++; $display("FAIL midrst_async: got req=%b addr=%h dv=%b dr=%h ifr=%h err=%b want all 0",
                         mem_req, mem_addr, d_valid, d_rdata, if_rdata, err);
    end
    d_req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({d_valid, if_valid, d_rdata, mem_req} !== '0) begin
        n_fail++; $display("FAIL midrst_stray_%0d: got dv=%b ifv=%b dr=%h req=%b want all 0",
                           i, d_valid, if_valid, d_rdata, mem_req);
      end
      tick();
    end
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL midrst_idle: got req=%b addr=%h want 1 00000040", mem_req, mem_addr);
    end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    n_checks++;
    if ({if_valid, if_rdata} !== {1'b1, 32'h5555_AAAA}) begin
      n_fail++; $display("FAIL midrst_after: got ifv=%b ifr=%h want 1 5555aaaa", if_valid, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    if_req = 1'b1; if_addr = 32'h800;
    tick();
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if ({mem_req, if_valid, err} !== 3'b100) begin
        n_fail++; $display("FAIL tmo_waiting_c%0d: got req=%b ifv=%b err=%b want 1 0 0", c, mem_req, if_valid, err);
      end
      tick();
    end
    n_checks++;
    if ({mem_req, if_valid, if_rdata, err} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL tmo_fire: got req=%b ifv=%b ifr=%h err=%b want 0 1 0 1", mem_req, if_valid, if_rdata, err);
    end
    if_req = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_rvalid = 1'b0;
    tick();
    n_checks++;
    if ({if_valid, if_rdata, err} !== {1'b0, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL tmo_sticky: got ifv=%b ifr=%h err=%b want 0 0 1", if_valid, if_rdata, err);
    end
    do_reset();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got err=%b want 0", err); end
  endtask
`endif

  // Random traffic against a transaction-level model: requesters hold requests
  // until their valid, memory grants/responds with random latency, and the
  // model predicts owner, payload, completion pulses and rdata.
  task automatic test_random(input int n_cycles);
    int          phase;        // 0: no transaction, 1: request outstanding, 2: granted
    int          cnt;
    int          iss_wait;
    int          phase_now;
    logic        owner_data;
    logic        last_data;
    logic        exp_ifv, exp_dv, cur_ifv, cur_dv, nxt_ifv, nxt_dv;
    logic [31:0] m_if_rdata, m_d_rdata;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [31:0] r;

    do_reset();
    phase = 0; cnt = 0; iss_wait = 0;
    owner_data = 1'b0; last_data = 1'b0;
    exp_ifv = 1'b0; exp_dv = 1'b0;
    m_if_rdata = '0; m_d_rdata = '0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;

    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      tick();
      phase_now = phase;
      cur_ifv = exp_ifv;
      cur_dv  = exp_dv;

      n_checks++;
      if ({if_valid, d_valid} !== {cur_ifv, cur_dv}) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got ifv=%b dv=%b want %b %b", cyc, if_valid, d_valid, cur_ifv, cur_dv);
      end
      n_checks++;
      if ({if_rdata, d_rdata} !== {m_if_rdata, m_d_rdata}) begin
        n_fail++; $display("FAIL rnd_rdata c%0d: got ifr=%h dr=%h want %h %h", cyc, if_rdata, d_rdata, m_if_rdata, m_d_rdata);
      end
      if (phase_now == 1) begin
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, e_we, e_addr, e_be} ||
            (e_we && mem_wdata !== e_wdata)) begin
          n_fail++; $display("FAIL rnd_issue c%0d: got req=%b we=%b addr=%h be=%h wd=%h want 1 %b %h %h %h",
                             cyc, mem_req, mem_we, mem_addr, mem_be, mem_wdata, e_we, e_addr, e_be, e_wdata);
        end
      end else begin
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_noreq c%0d: got %b want 0", cyc, mem_req); end
      end

      // memory side
      mem_gnt = 1'b0; mem_rvalid = 1'b0; r = $urandom; mem_rdata = r;
      nxt_ifv = 1'b0; nxt_dv = 1'b0;
      if (phase_now == 1) begin
        iss_wait++;
        r = $urandom;
        if (r[0] || iss_wait >= 4) begin
          mem_gnt = 1'b1;
          cnt = int'($urandom_range(3, 0));
          phase = (cnt == 0) ? 0 : 2;
          if (cnt == 0) mem_rvalid = 1'b1;
        end
      end else if (phase_now == 2) begin
        cnt--;
        if (cnt == 0) begin mem_rvalid = 1'b1; phase = 0; end
      end else begin
        r = $urandom;
        mem_gnt    = (r[3:0] == 4'd0);
        mem_rvalid = (r[7:4] == 4'd0);
      end
      if (phase_now != 0 && mem_rvalid) begin
        if (owner_data) begin nxt_dv = 1'b1; m_d_rdata = mem_rdata; end
        else begin nxt_ifv = 1'b1; m_if_rdata = mem_rdata; end
      end

      // requesters: a port changes its request only after its own valid
      if (cur_ifv || !if_req) begin
        r = $urandom;
        if_req  = cur_ifv ? r[0] : (r[1:0] == 2'b00);
        if_addr = {16'h0000, r[15:2], 2'b00};
      end
      if (cur_dv || !d_req) begin
        r = $urandom;
        d_req   = cur_dv ? r[0] : (r[1:0] == 2'b00);
        d_we    = r[2];
        d_be    = r[7:4];
        d_addr  = {16'h8000, r[23:10], 2'b00};
        d_wdata = $urandom;
      end

      // acceptance at the coming edge
      if (phase_now == 0 && !cur_ifv && !cur_dv && (if_req || d_req)) begin
        owner_data = d_req && (!if_req || !last_data);
        last_data  = owner_data;
        phase = 1; iss_wait = 0;
        if (owner_data) begin
          e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_we ? d_be : 4'hF;
        end else begin
          e_we = 1'b0; e_addr = if_addr; e_wdata = '0; e_be = 4'hF;
        end
      end
      exp_ifv = nxt_ifv;
      exp_dv  = nxt_dv;

      #1;
      n_checks++;
      if (stall !== ((if_req & ~cur_ifv) | (d_req & ~cur_dv))) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, stall, (if_req & ~cur_ifv) | (d_req & ~cur_dv));
      end
    end
`ifndef MEM_ARB_TIMEOUT_EN
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b want 0", err); end
`endif
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_same_cycle();
    test_reset_mid_op();
    test_random(3000);
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
